// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: op-code constants and FSM state encoding.
package seq_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_alu_mul.sv
// Radix-2 shift-add multiplier: the first partial product is taken on the start edge,
// and the remaining WIDTH-1 follow one per cycle; o_done pulses once the product is final.
module seq_alu_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (i_start) begin
      r_acc    <= i_b[0] ? {{WIDTH{1'b0}}, i_a} : '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a} << 1;
      r_mplier <= i_b >> 1;
      r_cnt    <= CW'(WIDTH - 1);
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
    end else if (r_busy) begin
      r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
      // The last partial product lands on this edge, so done is flagged alongside it.
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_done    = r_done;
  assign o_product = r_acc;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ADD/SUB/logic ops, multi-cycle shift-add MUL.
// Optional zero/overflow flag outputs are built when SEQ_ALU_FLAGS_EN is defined.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               carry_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               carry_out,
`ifdef SEQ_ALU_FLAGS_EN
  output logic               zero_flag,
  output logic               ovf_flag,
`endif
  output state_e             o_dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // a source holds its payload stable while valid && !ready.

  state_e             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [2*WIDTH-1:0] r_result;
  logic               r_cout;

  logic               w_accept;
  logic               w_mul_start;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_mul_product;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_alu_res;
  logic               w_alu_cout;

  assign w_accept    = in_valid && r_in_ready;
  assign w_mul_start = w_accept && (op == OP_MUL);

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_mul_start),
    .i_a       (a),
    .i_b       (b),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  // Bit WIDTH of the zero-extended difference is set exactly when a < b + carry_in.
  assign w_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
  assign w_diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, carry_in};

  always_comb begin
    w_alu_res  = '0;
    w_alu_cout = 1'b0;
    case (op)
      OP_ADD: begin
        w_alu_res  = {{WIDTH{1'b0}}, w_sum[WIDTH-1:0]};
        w_alu_cout = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_alu_res  = {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
        w_alu_cout = w_diff[WIDTH];
      end
      OP_AND:  w_alu_res = {{WIDTH{1'b0}}, a & b};
      OP_OR:   w_alu_res = {{WIDTH{1'b0}}, a | b};
      OP_XOR:  w_alu_res = {{WIDTH{1'b0}}, a ^ b};
      default: w_alu_res = '0;
    endcase
  end

`ifdef SEQ_ALU_FLAGS_EN
  logic           r_zero;
  logic           r_ovf;
  logic [WIDTH:0] w_sadd;
  logic [WIDTH:0] w_ssub;
  logic           w_alu_ovf;

  // Sign-extended sums never wrap in WIDTH+1 bits, so overflow is a top-two-bit mismatch.
  assign w_sadd    = {a[WIDTH-1], a} + {b[WIDTH-1], b} + {{WIDTH{1'b0}}, carry_in};
  assign w_ssub    = {a[WIDTH-1], a} - {b[WIDTH-1], b} - {{WIDTH{1'b0}}, carry_in};
  assign w_alu_ovf = (op == OP_ADD) ? (w_sadd[WIDTH] ^ w_sadd[WIDTH-1]) :
                     (op == OP_SUB) ? (w_ssub[WIDTH] ^ w_ssub[WIDTH-1]) : 1'b0;
  assign zero_flag = r_zero;
  assign ovf_flag  = r_ovf;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_cout      <= 1'b0;
`ifdef SEQ_ALU_FLAGS_EN
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            if (op == OP_MUL) begin
              r_state <= ST_BUSY;
            end else begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_alu_res;
              r_cout      <= w_alu_cout;
`ifdef SEQ_ALU_FLAGS_EN
              r_zero      <= (w_alu_res == '0);
              r_ovf       <= w_alu_ovf;
`endif
            end
          end
        end
        ST_BUSY: begin
          if (w_mul_done) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_mul_product;
            r_cout      <= 1'b0;
`ifdef SEQ_ALU_FLAGS_EN
            r_zero      <= (w_mul_product == '0);
            r_ovf       <= 1'b0;
`endif
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign carry_out   = r_cout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=8): vector table plus hand sequences for
// backpressure, mid-multiply reset and ignored inputs while busy.
module tb_seq_alu;
  import seq_alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        carry_out;
  state_e      dbg_state;
`ifdef SEQ_ALU_FLAGS_EN
  logic        zero_flag;
  logic        ovf_flag;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cin;
    logic [15:0] res;
    logic        cout;
  } vec_t;

  vec_t vecs[18];

  seq_alu #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .carry_in    (carry_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .carry_out   (carry_out),
`ifdef SEQ_ALU_FLAGS_EN
    .zero_flag   (zero_flag),
    .ovf_flag    (ovf_flag),
`endif
    .o_dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

`ifdef SEQ_ALU_FLAGS_EN
  function automatic logic exp_ovf(input vec_t v);
    int sa;
    int sb;
    int r;
    sa = v.a[7] ? int'(v.a) - 256 : int'(v.a);
    sb = v.b[7] ? int'(v.b) - 256 : int'(v.b);
    if (v.op == OP_ADD)      r = sa + sb + int'(v.cin);
    else if (v.op == OP_SUB) r = sa - sb - int'(v.cin);
    else                     r = 0;
    return (r > 127) || (r < -128);
  endfunction
`endif

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_after_hs", out_valid, 1'b0);
    check("in_ready_after_hs", in_ready, 1'b1);
    check("state_idle_after_hs", dbg_state, ST_IDLE);
  endtask

  // Driver: one full transaction; noisy keeps in_valid high with new operands after accept.
  task automatic run_txn(input vec_t v, input bit noisy);
    int lat;
    bit is_mul;
    is_mul = (v.op == OP_MUL);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1;
    op       = v.op;
    a        = v.a;
    b        = v.b;
    carry_in = v.cin;
    @(posedge clk);
    #1;
    lat = 1;
    if (noisy) begin
      op = OP_ADD;
      a  = 8'h11;
      b  = 8'h22;
    end else begin
      in_valid = 1'b0;
    end
    while (!out_valid && lat < 40) begin
      check("busy_in_ready", in_ready, 1'b0);
      check("busy_state", dbg_state, ST_BUSY);
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, is_mul ? 9 : 1);
    check("result", result, v.res);
    check("carry_out", carry_out, v.cout);
    check("in_ready_done", in_ready, 1'b0);
`ifdef SEQ_ALU_FLAGS_EN
    check("zero_flag", zero_flag, (v.res == 16'h0000));
    check("ovf_flag", ovf_flag, exp_ovf(v));
`endif
    handshake();
  endtask

  initial begin
    int seen_valid;
    vecs[0]  = '{OP_ADD, 8'd200, 8'd100, 1'b0, 16'h002C, 1'b1};
    vecs[1]  = '{OP_ADD, 8'd15,  8'd1,   1'b1, 16'h0011, 1'b0};
    vecs[2]  = '{OP_ADD, 8'hFF,  8'hFF,  1'b1, 16'h00FF, 1'b1};
    vecs[3]  = '{OP_ADD, 8'h7F,  8'h01,  1'b0, 16'h0080, 1'b0};
    vecs[4]  = '{OP_SUB, 8'd50,  8'd100, 1'b0, 16'h00CE, 1'b1};
    vecs[5]  = '{OP_SUB, 8'd100, 8'd25,  1'b0, 16'h004B, 1'b0};
    vecs[6]  = '{OP_SUB, 8'd10,  8'd9,   1'b1, 16'h0000, 1'b0};
    vecs[7]  = '{OP_SUB, 8'd0,   8'd0,   1'b1, 16'h00FF, 1'b1};
    vecs[8]  = '{OP_MUL, 8'd255, 8'd255, 1'b0, 16'hFE01, 1'b0};
    vecs[9]  = '{OP_MUL, 8'd12,  8'd13,  1'b1, 16'h009C, 1'b0};
    vecs[10] = '{OP_MUL, 8'd0,   8'd77,  1'b0, 16'h0000, 1'b0};
    vecs[11] = '{OP_MUL, 8'd128, 8'd2,   1'b0, 16'h0100, 1'b0};
    vecs[12] = '{OP_AND, 8'hD5,  8'hAA,  1'b1, 16'h0080, 1'b0};
    vecs[13] = '{OP_OR,  8'hD5,  8'hAA,  1'b0, 16'h00FF, 1'b0};
    vecs[14] = '{OP_XOR, 8'hD5,  8'hAA,  1'b1, 16'h007F, 1'b0};
    vecs[15] = '{OP_XOR, 8'h3C,  8'h3C,  1'b0, 16'h0000, 1'b0};
    vecs[16] = '{3'b110, 8'hFF,  8'h01,  1'b1, 16'h0000, 1'b0};
    vecs[17] = '{3'b111, 8'hFF,  8'hFF,  1'b1, 16'h0000, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = 3'b000;
    a         = '0;
    b         = '0;
    carry_in  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 16'h0000);
    check("rst_carry_out", carry_out, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) run_txn(vecs[i], 1'b0);

    // Inputs changing while busy or done must not disturb the multiply.
    run_txn(vecs[9], 1'b1);

    // Backpressure: result and out_valid held while the sink stalls.
    @(negedge clk);
    in_valid = 1'b1;
    op       = OP_AND;
    a        = 8'hD5;
    b        = 8'hAA;
    carry_in = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_result", result, 16'h0080);
      check("bp_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    check("bp_out_valid_end", out_valid, 1'b1);
    check("bp_result_end", result, 16'h0080);
    handshake();

    // Reset three cycles into a multiply aborts it.
    @(negedge clk);
    in_valid = 1'b1;
    op       = OP_MUL;
    a        = 8'd63;
    b        = 8'd63;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_mul_busy", dbg_state, ST_BUSY);
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_result", result, 16'h0000);
    check("abort_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid++;
    end
    check("abort_no_out_valid", seen_valid, 0);

    // Accept on the very first edge after reset release.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b1;
    op       = OP_ADD;
    a        = 8'd1;
    b        = 8'd1;
    carry_in = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("post_rst_out_valid", out_valid, 1'b1);
    check("post_rst_result", result, 16'h0002);
    check("post_rst_carry", carry_out, 1'b0);
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set operand width (legal range 4..32).
REQ-002 clk  input  1  SHALL be the sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 in_valid  input  1  SHALL indicate that op/a/b/carry_in hold a valid request.
REQ-005 in_ready  output  1  SHALL be high only in IDLE.
REQ-006 op  input  3  SHALL select the operation: 000 ADD, 001 SUB, 010 MUL, 011 AND, 100 OR, 101 XOR; 110/111 are invalid.
REQ-007 a, b  input  WIDTH  SHALL carry the unsigned operands.
REQ-008 carry_in  input  1  SHALL carry the carry (ADD) or borrow (SUB) input.
REQ-009 out_valid  output  1  SHALL indicate that result/carry_out are valid.
REQ-010 out_ready  input  1  SHALL accept the result from the sink.
REQ-011 result  output  2*WIDTH  SHALL carry the operation result.
REQ-012 carry_out  output  1  SHALL carry the carry (ADD) or borrow (SUB) output, and 0 for all other operations.

Function
REQ-013 The block SHALL accept a request on a rising edge where in_valid && in_ready, registering op, a, b and carry_in internally.
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE.
- IDLE->DONE on accept for any op other than MUL.
- IDLE->BUSY on accept for MUL.
- BUSY->DONE after WIDTH iterations.
- DONE->IDLE when out_ready is high.
REQ-015 ADD SHALL produce {carry_out, result[WIDTH-1:0]} = a + b + carry_in, with result[2*WIDTH-1:WIDTH] = 0.
REQ-016 SUB SHALL produce result[WIDTH-1:0] = a - b - carry_in modulo 2^WIDTH, with carry_out = 1 iff a < b + carry_in, and upper bits 0.
REQ-017 MUL SHALL produce the full unsigned product in result[2*WIDTH-1:0] by radix-2 shift-add, one partial product per cycle, ignoring carry_in.
REQ-018 AND, OR and XOR SHALL be bitwise on WIDTH bits, with upper bits 0 and carry_out 0.
REQ-019 An invalid op SHALL still complete as a single-cycle operation with result 0 and carry_out 0.
REQ-020 Latency from the accept edge to out_valid high SHALL be 1 cycle for non-MUL ops and WIDTH+1 cycles for MUL.
REQ-021 result, carry_out and out_valid SHALL be registered and held stable while out_valid && !out_ready.
REQ-022 out_valid SHALL fall on the edge where out_ready is sampled high in DONE.
REQ-023 in_ready SHALL rise one cycle after a DONE handshake, so there is no back-to-back accept in the same cycle.
REQ-024 Inputs presented while in_ready is low SHALL be ignored, and an in_valid change during BUSY SHALL have no effect.

Reset
REQ-025 Asserting rst SHALL immediately force state to IDLE, in_ready to 1, out_valid to 0, result to 0, carry_out to 0, and clear the multiplier accumulator and counter.
REQ-026 Reset asserted mid-MUL SHALL abort the operation, and no out_valid SHALL appear for the aborted request.
REQ-027 On rst deassertion the block SHALL accept a request on the first rising edge.

Configuration
REQ-028 With macro SEQ_ALU_FLAGS_EN defined, the block SHALL add two outputs, each registered with result and reset to 0:
- zero_flag (1): 1 iff result == 0.
- ovf_flag (1): ADD/SUB signed two's-complement overflow on WIDTH bits; 0 for all other ops.
REQ-029 Without SEQ_ALU_FLAGS_EN, the flag ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 Package seq_alu_pkg SHALL hold the op-code constants (OP_ADD..OP_XOR) and the FSM state encoding.
REQ-031 The shift-add multiplier SHALL be a sub-module seq_alu_mul, parametrised by WIDTH, with start/done ports, instantiated once.

Verification
REQ-032 With WIDTH=8, ADD a=200, b=100, carry_in=0 SHALL give result=0x002C and carry_out=1 one cycle after accept; with a=15, b=1, carry_in=1 it SHALL give 0x0011 and carry_out=0.
REQ-033 SUB a=50, b=100, carry_in=0 SHALL give result=0x00CE and carry_out=1; with a=100, b=25 it SHALL give 0x004B and carry_out=0.
REQ-034 MUL a=255, b=255 SHALL give result=0xFE01 exactly 9 cycles after accept, with in_ready low throughout BUSY.
REQ-035 Backpressure: AND a=0xD5, b=0xAA with out_ready held 0 for 5 cycles SHALL give result=0x0080 stable and out_valid high throughout, then a handshake, then in_ready high the next cycle.
REQ-036 rst asserted 3 cycles into MUL a=63, b=63 SHALL give out_valid=0 and in_ready=1 immediately; a following ADD 1+1 SHALL return 0x0002.
REQ-037 op=3'b111 SHALL give result=0 and carry_out=0 after 1 cycle; with SEQ_ALU_FLAGS_EN defined, zero_flag SHALL be 1.
